// File: rtl/chip8_mem_arbiter_if.sv
// Request/grant/data bundle between the CHIP-8 memory arbiter, its three
// requesters (loader, CPU, display) and the single-read/single-write memory.
interface chip8_mem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_done;
  logic              ld_gnt;
  logic              ld_rvalid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              cpu_run;

  logic [ADDR_W-1:0] rd_memory_address;
  logic [DATA_W-1:0] rd_memory_data;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_memory_address;
  logic [DATA_W-1:0] wr_memory_data;

  // Arbiter side.
  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr,
    input  rd_memory_data,
    output ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
    output rdata, cpu_run,
    output rd_memory_address, wr_go, wr_memory_address, wr_memory_data
  );

  // Requesters plus memory side.
  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata, ld_done,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr,
    output rd_memory_data,
    input  ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
    input  rdata, cpu_run,
    input  rd_memory_address, wr_go, wr_memory_address, wr_memory_data
  );
endinterface

// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 memory owner: boot gating (loader only until ld_done), then loader-first,
// CPU/display round-robin. Grants are combinational; read data returns 1 cycle later.
module chip8_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                 fpga_clk,
  input  logic                 rst_in,
  chip8_mem_arbiter_if.slave   bus
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  logic [1:0]  rst_sync_q;
  logic        rst_n;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        cpu_run_q;
  logic [2:0]  rvalid_q, rvalid_d;   // {ld, cpu, vid}

  logic        ld_gnt, cpu_gnt, vid_gnt, shared_ok;
  logic        ld_wr, cpu_wr, ld_rd, cpu_rd, vid_rd;

  // Reset asserts immediately, releases two edges after rst_in rises.
  always_ff @(posedge fpga_clk or negedge rst_in) begin
    if (!rst_in) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    ld_gnt    = rst_n & bus.ld_req;
    shared_ok = rst_n & (state_q == RUN) & ~bus.ld_req;
    // last_q = 1 means the display was served last, so the CPU wins a tie.
    cpu_gnt   = shared_ok & bus.cpu_req & (~bus.vid_req | last_q);
    vid_gnt   = shared_ok & bus.vid_req & (~bus.cpu_req | ~last_q);

    ld_wr  = ld_gnt  &  bus.ld_we;
    ld_rd  = ld_gnt  & ~bus.ld_we;
    cpu_wr = cpu_gnt &  bus.cpu_we;
    cpu_rd = cpu_gnt & ~bus.cpu_we;
    vid_rd = vid_gnt;

    rvalid_d = {ld_rd, cpu_rd, vid_rd};

    state_d = state_q;
    if (state_q == BOOT && bus.ld_done) state_d = RUN;

    last_d = last_q;
    if (cpu_gnt)      last_d = 1'b0;
    else if (vid_gnt) last_d = 1'b1;
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      cpu_run_q <= 1'b0;
      last_q    <= 1'b1;
      rvalid_q  <= 3'b000;
    end else begin
      state_q   <= state_d;
      cpu_run_q <= (state_d == RUN);
      last_q    <= last_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.ld_gnt  = ld_gnt;
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.vid_gnt = vid_gnt;

  assign bus.ld_rvalid  = rvalid_q[2];
  assign bus.cpu_rvalid = rvalid_q[1];
  assign bus.vid_rvalid = rvalid_q[0];
  assign bus.rdata      = (|rvalid_q) ? bus.rd_memory_data : '0;
  assign bus.cpu_run    = cpu_run_q;

  assign bus.wr_go             = ld_wr | cpu_wr;
  assign bus.wr_memory_address = ld_wr  ? bus.ld_addr  :
                                 cpu_wr ? bus.cpu_addr : '0;
  assign bus.wr_memory_data    = ld_wr  ? bus.ld_wdata  :
                                 cpu_wr ? bus.cpu_wdata : '0;
  assign bus.rd_memory_address = ld_rd  ? bus.ld_addr  :
                                 cpu_rd ? bus.cpu_addr :
                                 vid_rd ? bus.vid_addr : '0;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed bench for chip8_mem_arbiter with a 4 KiB registered-read memory model.
module tb_chip8_mem_arbiter;

  logic clk = 1'b0;
  logic rst_in;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter_if #(.ADDR_W(12), .DATA_W(8)) bus ();

  chip8_mem_arbiter #(.ADDR_W(12), .DATA_W(8)) dut (
    .fpga_clk (clk),
    .rst_in   (rst_in),
    .bus      (bus)
  );

  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.wr_go) mem[bus.wr_memory_address] <= bus.wr_memory_data;
    bus.rd_memory_data <= mem[bus.rd_memory_address];
  end

  typedef struct {
    logic        ld_req;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_done;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        vid_req;
    logic [11:0] vid_addr;
    logic [2:0]  gnt;    // {ld, cpu, vid}
    logic [2:0]  rv;     // {ld, cpu, vid}
    logic [7:0]  rdata;
    logic        wr_go;
    logic [11:0] wa;
    logic [7:0]  wd;
    logic [11:0] ra;
    logic        run;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic logic [47:0] observed();
    return {bus.ld_gnt, bus.cpu_gnt, bus.vid_gnt,
            bus.ld_rvalid, bus.cpu_rvalid, bus.vid_rvalid,
            bus.rdata, bus.wr_go, bus.wr_memory_address, bus.wr_memory_data,
            bus.rd_memory_address, bus.cpu_run};
  endfunction

  function automatic logic [47:0] expected(vec_t v);
    return {v.gnt, v.rv, v.rdata, v.wr_go, v.wa, v.wd, v.ra, v.run};
  endfunction

  task automatic check(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.ld_req    = v.ld_req;
    bus.ld_we     = v.ld_we;
    bus.ld_addr   = v.ld_addr;
    bus.ld_wdata  = v.ld_wdata;
    bus.ld_done   = v.ld_done;
    bus.cpu_req   = v.cpu_req;
    bus.cpu_we    = v.cpu_we;
    bus.cpu_addr  = v.cpu_addr;
    bus.cpu_wdata = v.cpu_wdata;
    bus.vid_req   = v.vid_req;
    bus.vid_addr  = v.vid_addr;
  endtask

  task automatic idle();
    bus.ld_req = 1'b0; bus.ld_we = 1'b0; bus.ld_addr = 12'h0; bus.ld_wdata = 8'h0;
    bus.ld_done = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 12'h0; bus.cpu_wdata = 8'h0;
    bus.vid_req = 1'b0; bus.vid_addr = 12'h0;
  endtask

  initial begin
    // ld_req we addr wdata done | cpu_req we addr wdata | vid_req addr | gnt rv rdata wr_go wa wd ra run
    vecs[0]  = '{1'b1,1'b1,12'h200,8'hA2,1'b0, 1'b1,1'b0,12'h100,8'h00, 1'b1,12'h300, 3'b100,3'b000,8'h00, 1'b1,12'h200,8'hA2, 12'h000,1'b0};
    vecs[1]  = '{1'b1,1'b0,12'h200,8'h00,1'b0, 1'b1,1'b0,12'h100,8'h00, 1'b1,12'h300, 3'b100,3'b000,8'h00, 1'b0,12'h000,8'h00, 12'h200,1'b0};
    vecs[2]  = '{1'b1,1'b1,12'h201,8'h33,1'b1, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b100,3'b100,8'hA2, 1'b1,12'h201,8'h33, 12'h000,1'b0};
    vecs[3]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b0,12'h000, 3'b010,3'b000,8'h00, 1'b0,12'h000,8'h00, 12'h200,1'b1};
    vecs[4]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b1,12'h201, 3'b001,3'b010,8'hA2, 1'b0,12'h000,8'h00, 12'h201,1'b1};
    vecs[5]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b010,3'b001,8'h33, 1'b0,12'h000,8'h00, 12'h200,1'b1};
    vecs[6]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b001,3'b010,8'hA2, 1'b0,12'h000,8'h00, 12'h201,1'b1};
    vecs[7]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b010,3'b001,8'h33, 1'b0,12'h000,8'h00, 12'h200,1'b1};
    vecs[8]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b001,3'b010,8'hA2, 1'b0,12'h000,8'h00, 12'h201,1'b1};
    vecs[9]  = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b010,3'b001,8'h33, 1'b0,12'h000,8'h00, 12'h200,1'b1};
    vecs[10] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h201, 3'b001,3'b010,8'hA2, 1'b0,12'h000,8'h00, 12'h201,1'b1};
    vecs[11] = '{1'b1,1'b0,12'h201,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h200, 3'b100,3'b001,8'h33, 1'b0,12'h000,8'h00, 12'h201,1'b1};
    vecs[12] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h200,8'h00, 1'b1,12'h200, 3'b010,3'b100,8'h33, 1'b0,12'h000,8'h00, 12'h200,1'b1};
    vecs[13] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b1,12'hFFF,8'h55, 1'b0,12'h000, 3'b010,3'b010,8'hA2, 1'b1,12'hFFF,8'h55, 12'h000,1'b1};
    vecs[14] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b1,12'hFFF, 3'b001,3'b000,8'h00, 1'b0,12'h000,8'h00, 12'hFFF,1'b1};
    vecs[15] = '{1'b0,1'b0,12'h000,8'h00,1'b1, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b000,3'b001,8'h55, 1'b0,12'h000,8'h00, 12'h000,1'b1};
    vecs[16] = '{1'b1,1'b1,12'h000,8'h77,1'b0, 1'b1,1'b1,12'h001,8'h99, 1'b0,12'h000, 3'b100,3'b000,8'h00, 1'b1,12'h000,8'h77, 12'h000,1'b1};
    vecs[17] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b1,12'h001,8'h99, 1'b0,12'h000, 3'b010,3'b000,8'h00, 1'b1,12'h001,8'h99, 12'h000,1'b1};
    vecs[18] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b1,1'b0,12'h001,8'h00, 1'b0,12'h000, 3'b010,3'b000,8'h00, 1'b0,12'h000,8'h00, 12'h001,1'b1};
    vecs[19] = '{1'b0,1'b0,12'h000,8'h00,1'b0, 1'b0,1'b0,12'h000,8'h00, 1'b0,12'h000, 3'b000,3'b010,8'h99, 1'b0,12'h000,8'h00, 12'h000,1'b1};

    // Reset with requests pending: everything quiet.
    rst_in = 1'b0;
    idle();
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 12'h123; bus.ld_wdata = 8'h45;
    bus.cpu_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset_quiet[%0d]", i), observed(), 48'h0);
    end
    @(negedge clk);
    idle();
    rst_in = 1'b1;
    repeat (3) @(negedge clk);

    // Boot gating: CPU and display requests are ignored.
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'h100;
    bus.vid_req = 1'b1; bus.vid_addr = 12'h300;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("boot_gate[%0d]", i), observed(), 48'h0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("vec[%0d]", i), observed(), expected(vecs[i]));
    end

    // Reset asserted during a CPU read grant.
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'h200;
    #1;
    check1("midop_gnt_before_reset", bus.cpu_gnt, 1'b1);
    #1 rst_in = 1'b0;
    #1;
    check("midop_outputs_in_reset", observed(), 48'h0);
    @(posedge clk); #1;
    check1("midop_no_rvalid", bus.cpu_rvalid, 1'b0);
    check1("midop_cpu_run", bus.cpu_run, 1'b0);
    repeat (2) @(negedge clk);
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("post_reset_boot[%0d]", i), observed(), 48'h0);
    end

    // Re-boot: pointer must be back at "display last", so CPU wins the first tie.
    @(negedge clk);
    idle();
    bus.ld_done = 1'b1;
    #1;
    check1("reboot_run_before", bus.cpu_run, 1'b0);
    @(negedge clk);
    idle();
    bus.cpu_req = 1'b1; bus.cpu_addr = 12'h200;
    bus.vid_req = 1'b1; bus.vid_addr = 12'h201;
    #1;
    check1("reboot_run_after", bus.cpu_run, 1'b1);
    check1("reboot_cpu_first", bus.cpu_gnt, 1'b1);
    check1("reboot_vid_waits", bus.vid_gnt, 1'b0);
    @(negedge clk); #1;
    check1("reboot_vid_second", bus.vid_gnt, 1'b1);
    check1("reboot_cpu_rvalid", bus.cpu_rvalid, 1'b1);
    check("reboot_cpu_rdata", {40'h0, bus.rdata}, 48'hA2);

    @(negedge clk);
    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
